// File: rtl/avmm_mem_slave.sv
// Avalon-MM memory slave with fixed read latency, reset-initialised contents
// and a sticky error flag for simultaneous read/write requests.
module avmm_mem_slave #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  read,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic                  waitrequest,
  output logic                  readdatavalid,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic                  err
);

  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NBYTES = (DATA_WIDTH + 7) / 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  in_range_q, in_range_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  logic                  addr_in_range;
  logic [IDX_W-1:0]      addr_idx;

  // Byte b of word i powers up as (8*i + b + 1) mod 256.
  function automatic logic [DATA_WIDTH-1:0] init_word(input int i);
    logic [DATA_WIDTH-1:0] w;
    logic [7:0]            byte_v;
    w = '0;
    for (int b = 0; b < NBYTES; b++) begin
      byte_v = 8'((8 * i + b + 1) % 256);
      w      = w | (DATA_WIDTH'(byte_v) << (8 * b));
    end
    return w;
  endfunction

  assign addr_in_range = (address < ADDR_WIDTH'(DEPTH));
  assign addr_idx      = address[IDX_W-1:0];

  assign waitrequest   = rst | (state_q == BUSY);
  assign readdatavalid = (state_q == RESP);
  assign readdata      = rdata_q;
  assign err           = err_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    in_range_d = in_range_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    mem_d      = mem_q;

    case (state_q)
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          rdata_d = in_range_q ? mem_q[idx_q] : '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        if (read) begin
          // A simultaneous write is dropped; the read wins and the error sticks.
          idx_d      = addr_idx;
          in_range_d = addr_in_range;
          err_d      = err_q | write;
          if (LATENCY == 1) begin
            state_d = RESP;
            rdata_d = addr_in_range ? mem_q[addr_idx] : '0;
          end else begin
            state_d = BUSY;
            cnt_d   = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
          end
        end else if (write && addr_in_range) begin
          mem_d[addr_idx] = writedata;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      in_range_q <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= init_word(i);
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      in_range_q <= in_range_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      mem_q      <= mem_d;
    end
  end

endmodule

// File: tb/tb_avmm_mem_slave.sv
// Bench for avmm_mem_slave: a LATENCY=2 and a LATENCY=1 instance share directed
// stimulus and are both checked every cycle against a transaction-level model.
module tb_avmm_mem_slave;

  logic        clk;
  logic        rst;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [63:0] wdata;

  logic [1:0]  wr_o;
  logic [1:0]  rdv_o;
  logic [1:0]  err_o;
  logic [63:0] rd_o0;
  logic [63:0] rd_o1;

  int nvec = 0;
  int nmis = 0;

  // Model state, one slot per instance (0: LATENCY=2, 1: LATENCY=1).
  int          cyc;
  int          next_ok [2];
  bit          pv      [2];
  int          pdue    [2];
  logic [63:0] pdata   [2];
  logic [63:0] mrdata  [2];
  bit          merr    [2];
  logic [63:0] mmem    [2][16];

  avmm_mem_slave dut (
    .clk(clk), .rst(rst), .address(addr), .read(rd), .write(wr), .writedata(wdata),
    .waitrequest(wr_o[0]), .readdatavalid(rdv_o[0]), .readdata(rd_o0), .err(err_o[0])
  );

  avmm_mem_slave #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .address(addr), .read(rd), .write(wr), .writedata(wdata),
    .waitrequest(wr_o[1]), .readdatavalid(rdv_o[1]), .readdata(rd_o1), .err(err_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  task automatic checkOutput(input string name, input int k, input logic [63:0] got,
                             input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("[TB] FAIL %s dut%0d at cycle %0d: got %h expected %h", name, k, cyc, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic rq, input logic wq,
                               input logic [31:0] a, input logic [63:0] d);
    rst   = r;
    rd    = rq;
    wr    = wq;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #2;
  endtask

  // Model update on each rising edge, then compare both instances just after it.
  always begin
    bit          exp_rdv;
    bit          exp_wr;
    logic [63:0] got_rd;
    @(posedge clk);
    if (rst) begin
      cyc = 0;
      for (int k = 0; k < 2; k++) begin
        next_ok[k] = 0;
        pv[k]      = 1'b0;
        merr[k]    = 1'b0;
        mrdata[k]  = '0;
        for (int i = 0; i < 16; i++)
          for (int b = 0; b < 8; b++)
            mmem[k][i][8*b +: 8] = 8'(8 * i + b + 1);
      end
    end else begin
      cyc++;
      for (int k = 0; k < 2; k++) begin
        if (cyc >= next_ok[k]) begin
          if (rd) begin
            pv[k]      = 1'b1;
            pdue[k]    = cyc + lat(k) - 1;
            pdata[k]   = (addr < 32'd16) ? mmem[k][addr[3:0]] : 64'd0;
            next_ok[k] = cyc + lat(k);
            if (wr) merr[k] = 1'b1;
          end else if (wr && addr < 32'd16) begin
            mmem[k][addr[3:0]] = wdata;
          end
        end
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      exp_rdv = !rst && pv[k] && (pdue[k] == cyc);
      if (exp_rdv) begin
        mrdata[k] = pdata[k];
        pv[k]     = 1'b0;
      end
      exp_wr = rst || (cyc + 1 < next_ok[k]);
      got_rd = (k == 0) ? rd_o0 : rd_o1;
      checkOutput("waitrequest", k, 64'(wr_o[k]), 64'(exp_wr));
      checkOutput("readdatavalid", k, 64'(rdv_o[k]), 64'(exp_rdv));
      checkOutput("err", k, 64'(err_o[k]), 64'(merr[k]));
      checkOutput("readdata", k, got_rd, mrdata[k]);
    end
  end

  initial begin
    rst   = 1'b1;
    rd    = 1'b0;
    wr    = 1'b0;
    addr  = '0;
    wdata = '0;

    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("rst_wait", 0, 64'(wr_o[0]), 64'd1);
    checkOutput("rst_rdata", 0, rd_o0, 64'd0);
    checkOutput("rst_err", 0, 64'(err_o[0]), 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("rel_wait", 0, 64'(wr_o[0]), 64'd0);

    // Single read of word 0
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("lat_wait", 0, 64'(wr_o[0]), 64'd1);
    checkOutput("lat_rdv_early", 0, 64'(rdv_o[0]), 64'd0);
    checkOutput("l1_rdv", 1, 64'(rdv_o[1]), 64'd1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("lat_rdv", 0, 64'(rdv_o[0]), 64'd1);
    checkOutput("lat_data", 0, rd_o0, 64'h0807060504030201);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("lat_rdv_once", 0, 64'(rdv_o[0]), 64'd0);
    checkOutput("lat_hold", 0, rd_o0, 64'h0807060504030201);

    // Back-to-back reads of words 1 and 15 with read held high
    applyStimulus(0, 1, 0, 1, 0);
    applyStimulus(0, 1, 0, 1, 0);
    checkOutput("b2b_rdv1", 0, 64'(rdv_o[0]), 64'd1);
    checkOutput("b2b_data1", 0, rd_o0, 64'h100F0E0D0C0B0A09);
    applyStimulus(0, 1, 0, 15, 0);
    checkOutput("b2b_gap", 0, 64'(rdv_o[0]), 64'd0);
    checkOutput("b2b_wait", 0, 64'(wr_o[0]), 64'd1);
    applyStimulus(0, 1, 0, 15, 0);
    checkOutput("b2b_rdv2", 0, 64'(rdv_o[0]), 64'd1);
    checkOutput("b2b_data2", 0, rd_o0, 64'h807F7E7D7C7B7A79);
    checkOutput("l1_stream_rdv", 1, 64'(rdv_o[1]), 64'd1);
    checkOutput("l1_stream_wait", 1, 64'(wr_o[1]), 64'd0);
    checkOutput("l1_stream_data", 1, rd_o1, 64'h807F7E7D7C7B7A79);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("b2b_no_dup", 0, 64'(rdv_o[0]), 64'd0);

    // Write then read back, in range and out of range
    applyStimulus(0, 0, 1, 3, 64'hDEADBEEFCAFEF00D);
    applyStimulus(0, 1, 0, 3, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("wr_rdv", 0, 64'(rdv_o[0]), 64'd1);
    checkOutput("wr_data", 0, rd_o0, 64'hDEADBEEFCAFEF00D);
    applyStimulus(0, 0, 1, 20, 64'h1234567812345678);
    applyStimulus(0, 1, 0, 20, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("oor_rdv", 0, 64'(rdv_o[0]), 64'd1);
    checkOutput("oor_data", 0, rd_o0, 64'd0);
    checkOutput("oor_err", 0, 64'(err_o[0]), 64'd0);

    // Simultaneous read and write: read wins, error sticks
    applyStimulus(0, 1, 1, 2, 64'hFFFFFFFFFFFFFFFF);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rw_data", 0, rd_o0, 64'h1817161514131211);
    checkOutput("rw_err", 0, 64'(err_o[0]), 64'd1);
    applyStimulus(0, 1, 0, 2, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rw_unchanged", 0, rd_o0, 64'h1817161514131211);
    checkOutput("rw_err_sticky", 0, 64'(err_o[0]), 64'd1);

    // Reset while a read is outstanding
    applyStimulus(0, 1, 0, 3, 0);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_wait", 0, 64'(wr_o[0]), 64'd1);
    checkOutput("mid_rst_rdv", 0, 64'(rdv_o[0]), 64'd0);
    checkOutput("mid_rst_rdata", 0, rd_o0, 64'd0);
    checkOutput("mid_rst_err", 0, 64'(err_o[0]), 64'd0);
    applyStimulus(1, 0, 0, 0, 0);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("mid_rst_drop1", 0, 64'(rdv_o[0]), 64'd0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("mid_rst_drop2", 0, 64'(rdv_o[0]), 64'd0);
    applyStimulus(0, 1, 0, 3, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("restored", 0, rd_o0, 64'h201F1E1D1C1B1A19);
    checkOutput("restored_l1", 1, rd_o1, 64'h201F1E1D1C1B1A19);

    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
